// File: rtl/uart_tx_sender.sv
// rtl/uart_tx_sender.sv - UART transmitter with a one-byte holding register and an 8N1/8N2 shifter
// Frames are LSB first; a byte waiting in hold is started in the same edge that ends the previous frame.
module uart_tx_sender #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       uart_tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] baud_cnt, baud_n;
  logic [2:0]       bit_idx, bit_n;
  logic             stop_idx, stop_n;
  logic [7:0]       shifter, shift_n;
  logic [7:0]       hold;
  logic             hold_valid;
  logic             tx_q, tx_n;
  logic             done_q, done_n;
  logic             load;
  logic             bit_end;
  logic             accept;

  assign accept  = tx_valid & ~hold_valid;
  assign bit_end = (baud_cnt == CNT_LAST);

  always_comb begin
    state_n = state;
    baud_n  = baud_cnt;
    bit_n   = bit_idx;
    stop_n  = stop_idx;
    shift_n = shifter;
    done_n  = 1'b0;
    load    = 1'b0;
    case (state)
      IDLE: begin
        if (hold_valid) begin
          load    = 1'b1;
          state_n = START;
          baud_n  = '0;
        end
      end
      START: begin
        if (bit_end) begin
          state_n = DATA;
          bit_n   = 3'd0;
          baud_n  = '0;
        end else begin
          baud_n = baud_cnt + CNT_W'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_n  = '0;
          shift_n = {1'b0, shifter[7:1]};
          if (bit_idx == 3'd7) begin
            state_n = STOP;
            stop_n  = 1'b0;
          end else begin
            bit_n = bit_idx + 3'd1;
          end
        end else begin
          baud_n = baud_cnt + CNT_W'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          baud_n = '0;
          if (stop_idx == STOP_LAST) begin
            done_n = 1'b1;
            if (hold_valid) begin
              load    = 1'b1;
              state_n = START;
            end else begin
              state_n = IDLE;
            end
          end else begin
            stop_n = 1'b1;
          end
        end else begin
          baud_n = baud_cnt + CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
    if (load) shift_n = hold;
  end

  // Line level is registered from the next state so uart_tx never glitches.
  always_comb begin
    tx_n = 1'b1;
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shift_n[0];
      default: tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_idx    <= 3'd0;
      stop_idx   <= 1'b0;
      shifter    <= 8'd0;
      hold       <= 8'd0;
      hold_valid <= 1'b0;
      tx_q       <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_n;
      bit_idx  <= bit_n;
      stop_idx <= stop_n;
      shifter  <= shift_n;
      tx_q     <= tx_n;
      done_q   <= done_n;
      if (accept) begin
        hold       <= tx_data;
        hold_valid <= 1'b1;
      end else if (load) begin
        hold_valid <= 1'b0;
      end
    end
  end

  assign tx_ready = ~hold_valid;
  assign uart_tx  = tx_q;
  assign tx_busy  = (state != IDLE);
  assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx_sender.sv
// tb/tb_uart_tx_sender.sv - bench for uart_tx_sender at 4 clk/bit 1 stop and 3 clk/bit 2 stops
// Expected line/busy/done/ready come from a frame-timeline model built from accept times.
module tb_uart_tx_sender;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tx_valid [2];
  logic [7:0] tx_data  [2];
  logic       tx_ready [2];
  logic       uart_tx  [2];
  logic       tx_busy  [2];
  logic       tx_done  [2];

  always #5 clk = ~clk;

  uart_tx_sender #(.CLKS_PER_BIT(4), .STOP_BITS(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .tx_valid(tx_valid[0]), .tx_data(tx_data[0]),
    .tx_ready(tx_ready[0]), .uart_tx(uart_tx[0]), .tx_busy(tx_busy[0]), .tx_done(tx_done[0])
  );

  uart_tx_sender #(.CLKS_PER_BIT(3), .STOP_BITS(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .tx_valid(tx_valid[1]), .tx_data(tx_data[1]),
    .tx_ready(tx_ready[1]), .uart_tx(uart_tx[1]), .tx_busy(tx_busy[1]), .tx_done(tx_done[1])
  );

  typedef struct {
    int         d;
    int         a;
    int         s;
    logic [7:0] b;
  } frame_t;

  int         cpb   [2] = '{4, 3};
  int         sbits [2] = '{1, 2};
  frame_t     frames[$];
  int         last_end [2];
  logic [7:0] src0[$];
  logic [7:0] src1[$];
  bit         presenting [2];
  int         start_pct;
  bit         garble;
  bit         rand_mode;
  int         cyc;
  int         compared;
  int         mismatched;

  function automatic int flen(int d);
    return (9 + sbits[d]) * cpb[d];
  endfunction

  function automatic bit src_empty(int d);
    return (d == 0) ? (src0.size() == 0) : (src1.size() == 0);
  endfunction

  function automatic logic [7:0] src_front(int d);
    return (d == 0) ? src0[0] : src1[0];
  endfunction

  task automatic src_pop(int d);
    if (d == 0) void'(src0.pop_front());
    else        void'(src1.pop_front());
  endtask

  task automatic push_both(logic [7:0] b);
    src0.push_back(b);
    src1.push_back(b);
  endtask

  // Hold is occupied from the accept edge until the edge that starts its frame.
  function automatic bit m_ready(int d, int c);
    foreach (frames[i])
      if (frames[i].d == d && frames[i].a <= c && c < frames[i].s) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void m_expect(int d, int c, output logic line, output logic busy,
                                   output logic done);
    logic [7:0] tmp;
    int         k;
    line = 1'b1;
    busy = 1'b0;
    done = 1'b0;
    foreach (frames[i]) begin
      if (frames[i].d == d) begin
        if (c >= frames[i].s && c < frames[i].s + flen(d)) begin
          busy = 1'b1;
          k = (c - frames[i].s) / cpb[d];
          if (k == 0) line = 1'b0;
          else if (k <= 8) begin
            tmp  = frames[i].b >> (k - 1);
            line = tmp[0];
          end else line = 1'b1;
        end
        if (c == frames[i].s + flen(d)) done = 1'b1;
      end
    end
  endfunction

  function automatic int find_s(int d);
    int r = -1;
    foreach (frames[i]) if (frames[i].d == d) r = frames[i].s;
    return r;
  endfunction

  task automatic chk(string tag, int d, logic obs, logic exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s dut%0d cyc=%0d observed=%b expected=%b", tag, d, cyc, obs, exp);
    end
  endtask

  task automatic step(input logic rst);
    bit     acc [2];
    frame_t fr;
    int     i;
    logic   e_line, e_busy, e_done;
    rst_n = rst;
    if (rand_mode) start_pct = $urandom_range(100);
    for (int d = 0; d < 2; d++) begin
      if (!presenting[d] && !src_empty(d) && ($urandom_range(99) < start_pct))
        presenting[d] = 1'b1;
      tx_valid[d] = presenting[d];
      if (presenting[d] && !(garble && !m_ready(d, cyc))) tx_data[d] = src_front(d);
      else tx_data[d] = 8'($urandom);
      acc[d] = rst && presenting[d] && m_ready(d, cyc);
    end
    @(posedge clk);
    cyc++;
    if (!rst) begin
      frames.delete();
      last_end = '{0, 0};
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (acc[d]) begin
          fr.d = d;
          fr.a = cyc;
          fr.s = (cyc + 1 > last_end[d]) ? cyc + 1 : last_end[d];
          fr.b = src_front(d);
          frames.push_back(fr);
          last_end[d] = fr.s + flen(d);
          src_pop(d);
          presenting[d] = 1'b0;
        end
      end
    end
    i = 0;
    while (i < frames.size()) begin
      if (frames[i].s + flen(frames[i].d) < cyc) frames.delete(i);
      else i++;
    end
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      m_expect(d, cyc, e_line, e_busy, e_done);
      chk("uart_tx",  d, uart_tx[d],  e_line);
      chk("tx_busy",  d, tx_busy[d],  e_busy);
      chk("tx_done",  d, tx_done[d],  e_done);
      chk("tx_ready", d, tx_ready[d], m_ready(d, cyc));
    end
  endtask

  task automatic drain(int bound);
    int n = 0;
    while (n < bound && !(frames.size() == 0 && src_empty(0) && src_empty(1) &&
                          !presenting[0] && !presenting[1])) begin
      step(1'b1);
      n++;
    end
    compared++;
    assert (n < bound) else begin
      mismatched++;
      $error("FAIL drain_timeout cyc=%0d observed=%0d steps expected=<%0d", cyc, n, bound);
    end
  endtask

  initial begin
    int s0;
    int n;
    compared   = 0;
    mismatched = 0;
    cyc        = 0;
    start_pct  = 100;
    garble     = 1'b0;
    rand_mode  = 1'b0;
    last_end   = '{0, 0};
    presenting = '{1'b0, 1'b0};
    rst_n      = 1'b0;
    for (int d = 0; d < 2; d++) begin
      tx_valid[d] = 1'b0;
      tx_data[d]  = 8'h00;
    end

    step(1'b0);
    step(1'b0);
    for (int k = 0; k < 50; k++) step(1'b1);

    push_both(8'hA5);
    drain(200);

    push_both(8'h55);
    push_both(8'h0F);
    drain(300);

    garble = 1'b1;
    push_both(8'h01);
    push_both(8'h02);
    push_both(8'h03);
    drain(400);

    push_both(8'hFF);
    n = 0;
    while (find_s(0) < 0 && n < 100) begin
      step(1'b1);
      n++;
    end
    s0 = find_s(0);
    compared++;
    assert (s0 >= 0) else begin
      mismatched++;
      $error("FAIL locate_ff cyc=%0d observed=%0d expected=>=0", cyc, s0);
    end
    while (s0 >= 0 && cyc < s0 + 17) step(1'b1);
    step(1'b0);
    presenting = '{1'b0, 1'b0};
    src0.delete();
    src1.delete();
    push_both(8'h3C);
    drain(200);

    rand_mode = 1'b1;
    for (int k = 0; k < 150; k++) push_both(8'($urandom));
    drain(20000);
    rand_mode = 1'b0;
    for (int k = 0; k < 10; k++) step(1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
